raymarch_frame_sequencer: RTL and testbench
===========================================

# raymarch_frame_sequencer

Drives the raymarcher one pixel at a time across a full WIDTH×HEIGHT frame in raster order. It issues each pixel's coordinates, waits for the raymarcher's done strobe and captures the returned colour. Each result is packed to RGB565 and queued in a small FIFO. The FIFO drains to the frame-buffer write port under valid/ready backpressure. The block sits between the frame controller and the raymarcher / frame-buffer BRAM.

## Interface
- WIDTH, 300, pixels per row
- HEIGHT, 300, rows per frame
- COORD_W, 33, width of pixel coordinate buses to/from the raymarcher
- ADDR_W, 17, frame-buffer address width (must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT)
- FIFO_DEPTH, 4, result FIFO entries (power of two, ≥2)

Ports:
- clk_in  in  1  system clock; all logic on rising edge
- rst_n_in  in  1  reset, asynchronous assert, active-low
- frame_start_in  in  1  one-cycle request to render a frame; honoured only in IDLE
- busy_out  out  1  high from frame accept until frame_done_out
- frame_done_out  out  1  one-cycle pulse when the last pixel is written to the frame buffer
- err_out  out  1  sticky coordinate-mismatch flag; cleared by reset or an accepted frame_start_in
- rm_x_out, rm_y_out  out  COORD_W  pixel coordinates presented to the raymarcher
- rm_start_out  out  1  one-cycle pulse launching a ray for rm_x_out/rm_y_out
- rm_done_in  in  1  raymarcher pixel_done strobe
- rm_x_in, rm_y_in  in  COORD_W  raymarcher echoed out_x/out_y
- rm_red_in, rm_green_in, rm_blue_in  in  8 each  raymarcher colour
- fb_valid_out  out  1  write request to the frame buffer
- fb_ready_in  in  1  frame buffer accepts the write this cycle
- fb_addr_out  out  ADDR_W  write address = y*WIDTH + x
- fb_data_out  out  16  {red[7:3], green[7:2], blue[7:3]}

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN.
- IDLE:
  - On frame_start_in: zero the x, y and addr counters, clear err_out, set busy_out, go to ISSUE.
- ISSUE:
  - rm_x_out/rm_y_out hold the current x/y (zero-extended).
  - If FIFO count < FIFO_DEPTH: pulse rm_start_out and go to WAIT.
  - Otherwise hold in ISSUE with rm_start_out low.
- WAIT:
  - rm_done_in is sampled only here; at most one ray is outstanding.
  - On rm_done_in: push {addr, packed colour} into the FIFO.
  - Compare rm_x_in/rm_y_in with the issued x/y; on mismatch set err_out. The issued addr is used regardless.
  - If x==WIDTH-1 and y==HEIGHT-1: go to DRAIN.
  - Otherwise advance: x+1, or wrap to x=0, y+1 when x==WIDTH-1; addr+1; go to ISSUE.
- DRAIN:
  - When the FIFO is empty and no write is pending: pulse frame_done_out, clear busy_out, go to IDLE.
- rm_done_in outside WAIT is ignored. frame_start_in outside IDLE is ignored.
- FIFO output side runs in every state:
  - fb_valid_out = FIFO non-empty; fb_addr_out/fb_data_out show the head entry.
  - Pop when fb_valid_out && fb_ready_in.
  - Head entry and fb_valid_out stay stable while fb_ready_in is low.
- FIFO push and pop in the same cycle leave the count unchanged. This is legal when full, though ISSUE guarantees a push never arrives while full without a slot.
- Addresses are produced by the incrementing counter; no multiplier.

## Timing
- Reset values:
  - rm_x_out=0, rm_y_out=0, rm_start_out=0
  - fb_valid_out=0, fb_addr_out=0, fb_data_out=0
  - busy_out=0, frame_done_out=0, err_out=0
  - FIFO empty, state IDLE
- Async assert at any point, including mid-frame, abandons the frame: the FIFO is flushed and no further writes occur. Deassertion is synchronised by the system.
- Cycle N frame_start_in → N+1 busy_out=1, state ISSUE → N+2 rm_start_out=1 (FIFO empty).
- rm_done_in in cycle M → FIFO entry visible with fb_valid_out=1 at M+1. Next rm_start_out no earlier than M+2.
- frame_done_out asserts the cycle after the last pop, coincident with busy_out falling.
- All outputs registered.

## Test plan
- WIDTH=4, HEIGHT=3 model raymarcher, done 3 cycles after start, fb_ready_in=1 → exactly 12 writes with addr 0..11 in order, colour (0xFF,0x00,0xFF) gives data 0xF81F, one frame_done_out pulse, err_out=0.
- Same setup, fb_ready_in held low → after 4 writes are queued rm_start_out stops. fb_valid_out is held with addr 0 stable. Releasing ready resumes the frame and completes all 12.
- Model returns rm_x_in wrong for pixel (2,1) → err_out sets at that capture and stays high. fb_addr_out for that entry = 6. err_out clears on the next frame_start_in.
- rm_done_in pulsed during ISSUE and IDLE, frame_start_in pulsed mid-frame → no extra FIFO pushes, write count stays 12.
- Reset asserted after the 5th write with FIFO non-empty → all outputs at reset values immediately. A new frame then starts at addr 0.
- Row wrap at x=3,y=0 → next issue is rm_x_out=0, rm_y_out=1, address 4.

Source files
------------

// File: rtl/raymarch_frame_sequencer.sv
// Walks a WIDTH x HEIGHT frame in raster order through the raymarcher, packs each
// returned colour to RGB565 and drains it to the frame buffer through a small FIFO.
module raymarch_frame_sequencer #(
  parameter int unsigned WIDTH      = 300,
  parameter int unsigned HEIGHT     = 300,
  parameter int unsigned COORD_W    = 33,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               frame_start_in,
  output logic               busy_out,
  output logic               frame_done_out,
  output logic               err_out,
  output logic [COORD_W-1:0] rm_x_out,
  output logic [COORD_W-1:0] rm_y_out,
  output logic               rm_start_out,
  input  logic               rm_done_in,
  input  logic [COORD_W-1:0] rm_x_in,
  input  logic [COORD_W-1:0] rm_y_in,
  input  logic [7:0]         rm_red_in,
  input  logic [7:0]         rm_green_in,
  input  logic [7:0]         rm_blue_in,
  output logic               fb_valid_out,
  input  logic               fb_ready_in,
  output logic [ADDR_W-1:0]  fb_addr_out,
  output logic [15:0]        fb_data_out
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = ADDR_W + 16;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  localparam logic [COORD_W-1:0] XLast = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] YLast = COORD_W'(HEIGHT - 1);
  localparam logic [CntW-1:0]    Depth = CntW'(FIFO_DEPTH);

  logic [1:0]         state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d, start_q, start_d;

  logic [EntW-1:0]    mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               push, pop;
  logic [15:0]        pixel_rgb;
  logic               unused_colour;

  assign pixel_rgb     = {rm_red_in[7:3], rm_green_in[7:2], rm_blue_in[7:3]};
  assign unused_colour = ^{rm_red_in[2:0], rm_green_in[1:0], rm_blue_in[2:0]};

  assign push = (state_q == StWait) && rm_done_in;
  assign pop  = (cnt_q != '0) && fb_ready_in;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    busy_d  = busy_q;
    err_d   = err_q;
    done_d  = 1'b0;
    start_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_start_in) begin
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (cnt_q < Depth) begin
          start_d = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (rm_done_in) begin
          if ((rm_x_in != x_q) || (rm_y_in != y_q)) err_d = 1'b1;
          if ((x_q == XLast) && (y_q == YLast)) begin
            state_d = StDrain;
          end else begin
            if (x_q == XLast) begin
              x_d = '0;
              y_d = y_q + COORD_W'(1);
            end else begin
              x_d = x_q + COORD_W'(1);
            end
            addr_d  = addr_q + ADDR_W'(1);
            state_d = StIssue;
          end
        end
      end
      default: begin
        // Finish on the cycle the last entry leaves, so done lands right after that pop.
        if (cnt_d == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
    end
  end

  // Storage is cleared on reset so the head outputs read zero after an abandoned frame.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {addr_q, pixel_rgb};
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q <= cnt_d;
    end
  end

  assign busy_out       = busy_q;
  assign frame_done_out = done_q;
  assign err_out        = err_q;
  assign rm_x_out       = x_q;
  assign rm_y_out       = y_q;
  assign rm_start_out   = start_q;
  assign fb_valid_out   = (cnt_q != '0);
  assign fb_addr_out    = mem_q[rd_ptr_q][EntW-1:16];
  assign fb_data_out    = mem_q[rd_ptr_q][15:0];

endmodule

// File: tb/tb_raymarch_frame_sequencer.sv
// Directed bench for raymarch_frame_sequencer on a 4x3 frame with a 3-cycle raymarcher model.
module tb_raymarch_frame_sequencer;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;
  localparam int unsigned CW = 33;
  localparam int unsigned AW = 17;
  localparam int unsigned FD = 4;
  localparam int          NPIX = 12;
  localparam logic [15:0] ExpData = 16'hF81F;

  logic          clk = 1'b0;
  logic          rst_n, frame_start, rm_done, fb_ready;
  logic [CW-1:0] rm_x_i, rm_y_i;
  logic [7:0]    red, green, blue;
  logic          busy_out, frame_done_out, err_out, rm_start_out, fb_valid_out;
  logic [CW-1:0] rm_x_out, rm_y_out;
  logic [AW-1:0] fb_addr_out;
  logic [15:0]   fb_data_out;

  always #5 clk = ~clk;

  raymarch_frame_sequencer #(
    .WIDTH(W), .HEIGHT(H), .COORD_W(CW), .ADDR_W(AW), .FIFO_DEPTH(FD)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n), .frame_start_in(frame_start),
    .busy_out(busy_out), .frame_done_out(frame_done_out), .err_out(err_out),
    .rm_x_out(rm_x_out), .rm_y_out(rm_y_out), .rm_start_out(rm_start_out),
    .rm_done_in(rm_done), .rm_x_in(rm_x_i), .rm_y_in(rm_y_i),
    .rm_red_in(red), .rm_green_in(green), .rm_blue_in(blue),
    .fb_valid_out(fb_valid_out), .fb_ready_in(fb_ready),
    .fb_addr_out(fb_addr_out), .fb_data_out(fb_data_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Controls owned by the main sequence.
  bit corrupt_en = 1'b0, spurious_en = 1'b0, spurious_req = 1'b0;

  // Monitor: cycle count, frame-buffer writes, err_out rising edge.
  int            cyc = 0, wr_cnt = 0, err_rise = -1;
  logic [AW-1:0] wr_addr [512];
  logic [15:0]   wr_data [512];
  logic          err_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      #2;
      if (fb_valid_out === 1'b1 && fb_ready === 1'b1 && wr_cnt < 512) begin
        wr_addr[wr_cnt] = fb_addr_out;
        wr_data[wr_cnt] = fb_data_out;
        wr_cnt++;
      end
      if (err_out === 1'b1 && err_prev === 1'b0) err_rise = cyc;
      err_prev = err_out;
    end
  end

  // Raymarcher model: done three cycles after each start, echoing the issued coordinates.
  int            pend = 0, iss_cnt = 0, bad_cyc = -1;
  bit            echo_again = 1'b0;
  logic [CW-1:0] cap_x, cap_y;
  logic [CW-1:0] iss_x [512];
  logic [CW-1:0] iss_y [512];

  initial begin
    rm_done = 1'b0;
    rm_x_i  = '0;
    rm_y_i  = '0;
    forever begin
      @(negedge clk);
      #1;
      rm_done = 1'b0;
      if (rst_n !== 1'b1) begin
        pend       = 0;
        echo_again = 1'b0;
      end else begin
        if (echo_again) begin
          rm_done    = 1'b1;
          echo_again = 1'b0;
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            rm_done = 1'b1;
            rm_x_i  = cap_x;
            rm_y_i  = cap_y;
            if (corrupt_en && cap_x == CW'(2) && cap_y == CW'(1)) begin
              rm_x_i  = cap_x + CW'(1);
              bad_cyc = cyc;
            end
            echo_again = spurious_en;
          end
        end
        if (spurious_req) rm_done = 1'b1;
        if (rm_start_out === 1'b1) begin
          pend  = 3;
          cap_x = rm_x_out;
          cap_y = rm_y_out;
          if (iss_cnt < 512) begin
            iss_x[iss_cnt] = rm_x_out;
            iss_y[iss_cnt] = rm_y_out;
          end
          iss_cnt++;
        end
      end
    end
  end

  task automatic start_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("busy_n1", 64'(busy_out), 64'(1));
    check("err_clear", 64'(err_out), 64'(0));
    check("start_n1", 64'(rm_start_out), 64'(0));
    @(negedge clk);
    check("start_n2", 64'(rm_start_out), 64'(1));
    check("issue_xy0", 64'({rm_x_out[1:0], rm_y_out[1:0]}), 64'(0));
  endtask

  task automatic wait_done(input bit toggle, input bit midstart, output int dones);
    int k = 0;
    int after = -1;
    dones = 0;
    while (k < 600 && after < 8) begin
      @(negedge clk);
      k++;
      if (toggle) fb_ready = k[0];
      frame_start = midstart && (k == 10);
      if (frame_done_out === 1'b1) begin
        dones++;
        if (after < 0) after = 0;
      end
      if (after >= 0) after++;
    end
    frame_start = 1'b0;
    fb_ready    = 1'b1;
  endtask

  task automatic check_frame(input int base, input string tag);
    bit ok = 1'b1;
    check({tag, "_writes"}, 64'(wr_cnt - base), 64'(NPIX));
    for (int i = 0; i < NPIX; i++) begin
      if (wr_addr[base+i] !== AW'(i) || wr_data[base+i] !== ExpData) ok = 1'b0;
    end
    check({tag, "_order"}, 64'(ok), 64'(1));
  endtask

  typedef struct {
    bit corrupt;
    bit spurious;
    bit toggle;
    bit exp_err;
  } vec_t;

  vec_t tbl [4];
  int   base, ibase, dones, snap;

  initial begin
    tbl[0] = '{corrupt: 1'b0, spurious: 1'b0, toggle: 1'b0, exp_err: 1'b0};
    tbl[1] = '{corrupt: 1'b1, spurious: 1'b0, toggle: 1'b0, exp_err: 1'b1};
    tbl[2] = '{corrupt: 1'b0, spurious: 1'b1, toggle: 1'b0, exp_err: 1'b0};
    tbl[3] = '{corrupt: 1'b0, spurious: 1'b0, toggle: 1'b1, exp_err: 1'b0};

    rst_n = 1'b1; frame_start = 1'b0; fb_ready = 1'b1;
    red = 8'hFF; green = 8'h00; blue = 8'hFF;
    #1 rst_n = 1'b0;
    #1;
    check("rst_ctrl", 64'({busy_out, frame_done_out, err_out, rm_start_out, fb_valid_out}), 64'(0));
    check("rst_fb", 64'({fb_addr_out, fb_data_out}), 64'(0));
    check("rst_xy", 64'({rm_x_out, rm_y_out}), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 4; r++) begin
      corrupt_en  = tbl[r].corrupt;
      spurious_en = tbl[r].spurious;
      if (tbl[r].spurious) begin
        @(negedge clk); spurious_req = 1'b1;
        @(negedge clk); spurious_req = 1'b0;
      end
      base = wr_cnt;
      start_frame();
      wait_done(tbl[r].toggle, tbl[r].spurious, dones);
      check("done_pulses", 64'(dones), 64'(1));
      check_frame(base, "frame");
      check("err_final", 64'(err_out), 64'(tbl[r].exp_err));
      check("idle_after", 64'({busy_out, fb_valid_out}), 64'(0));
      if (tbl[r].corrupt) check("err_rise_cycle", 64'(err_rise), 64'(bad_cyc + 1));
    end
    corrupt_en  = 1'b0;
    spurious_en = 1'b0;

    // Backpressure: four rays fill the FIFO, then issue stalls on pixel (0,1).
    fb_ready = 1'b0;
    base  = wr_cnt;
    ibase = iss_cnt;
    start_frame();
    repeat (40) @(negedge clk);
    check("bp_issues", 64'(iss_cnt - ibase), 64'(FD));
    check("bp_no_writes", 64'(wr_cnt - base), 64'(0));
    check("bp_head", 64'({fb_valid_out, fb_addr_out, fb_data_out}), 64'({1'b1, AW'(0), ExpData}));
    check("bp_start_low", 64'(rm_start_out), 64'(0));
    check("wrap_hold_xy", 64'({rm_x_out[7:0], rm_y_out[7:0]}), 64'({8'd0, 8'd1}));
    check("wrap_prev_issue", 64'({iss_x[ibase+3][7:0], iss_y[ibase+3][7:0]}), 64'({8'd3, 8'd0}));
    fb_ready = 1'b1;
    wait_done(1'b0, 1'b0, dones);
    check("bp_done", 64'(dones), 64'(1));
    check_frame(base, "bp");
    check("wrap_issue", 64'({iss_x[ibase+4][7:0], iss_y[ibase+4][7:0]}), 64'({8'd0, 8'd1}));

    // Reset mid-frame with the FIFO holding entries.
    base = wr_cnt;
    start_frame();
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      #3;
      if (wr_cnt - base >= 5) break;
    end
    check("mid_five_writes", 64'(wr_cnt - base >= 5), 64'(1));
    @(negedge clk);
    fb_ready = 1'b0;
    repeat (12) @(negedge clk);
    check("mid_fifo_full", 64'(fb_valid_out), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", 64'({busy_out, frame_done_out, err_out, rm_start_out, fb_valid_out}), 64'(0));
    check("mid_rst_fb", 64'({fb_addr_out, fb_data_out}), 64'(0));
    check("mid_rst_xy", 64'({rm_x_out, rm_y_out}), 64'(0));
    snap = wr_cnt;
    fb_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("mid_rst_no_writes", 64'(wr_cnt - snap), 64'(0));
    rst_n = 1'b1;
    base = wr_cnt;
    start_frame();
    wait_done(1'b0, 1'b0, dones);
    check("post_rst_done", 64'(dones), 64'(1));
    check_frame(base, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
